// File: rtl/div_pkg.sv
// Shared types for the divider issue stage: request/response payloads and
// the sequencer state encoding.
package div_pkg;

  localparam int DIV_W = 32;

  typedef struct packed {
    logic [DIV_W-1:0] dividend;
    logic [DIV_W-1:0] divisor;
  } div_req_t;

  typedef struct packed {
    logic [DIV_W-1:0] quotient;
    logic [DIV_W-1:0] remainder;
    logic             div0;
  } div_rsp_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    HOLD
  } seq_state_e;

endpackage

// File: rtl/div_req_fifo.sv
// Request FIFO for the divider sequencer. Power-of-two depth, pointers wrap
// naturally, push and pop in the same cycle leave the count unchanged.
// A push is ignored while full, a pop is ignored while empty.
module div_req_fifo
  import div_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  div_req_t               push_data,
  input  logic                   pop,
  output div_req_t               head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW:0]   CNT_ONE = (PW + 1)'(1);
  localparam logic [PW:0]   CNT_MAX = (PW + 1)'(DEPTH);

  div_req_t       mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == CNT_MAX);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage array: written on accepted push.
  // NOTE: the payload array has no reset; only pointers/count define validity,
  // so resetting it would just cost flops.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy tracking.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/div_req_sequencer.sv
// Issue stage for the 32-bit divider: queues operand pairs, issues one at a
// time with a single-cycle div_start, captures the result when the divider
// raises div_ready and holds it for a valid/ready consumer.
// Optional build macro DIV_ZERO_BYPASS_EN: a zero divisor is answered
// locally (quotient all ones, remainder = dividend, rsp_div0 = 1) without
// starting the divider.
module div_req_sequencer
  import div_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = DIV_W   // must equal DIV_W; payload structs are fixed width
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [WIDTH-1:0]       req_dividend,
  input  logic [WIDTH-1:0]       req_divisor,
  output logic                   div_start,
  output logic [WIDTH-1:0]       div_dividend,
  output logic [WIDTH-1:0]       div_divisor,
  input  logic                   div_ready,
  input  logic [WIDTH-1:0]       div_quotient,
  input  logic [WIDTH-1:0]       div_remainder,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH-1:0]       rsp_quotient,
  output logic [WIDTH-1:0]       rsp_remainder,
  output logic                   rsp_div0,
  output logic [$clog2(DEPTH):0] fifo_count
);

  div_req_t   fifo_in;
  div_req_t   fifo_head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_pop;
  logic       bypass;
  seq_state_e state;
  seq_state_e state_next;
  div_rsp_t   rsp_q;

  assign fifo_in.dividend = req_dividend;
  assign fifo_in.divisor  = req_divisor;

  // req_ready depends only on registered occupancy, never on req_valid.
  assign req_ready = !fifo_full;

  div_req_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (req_valid),
    .push_data (fifo_in),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

`ifdef DIV_ZERO_BYPASS_EN
  assign bypass = (fifo_head.divisor == '0);
`else
  assign bypass = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic: one request in flight, IDLE -> ISSUE -> WAIT -> HOLD.
  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!fifo_empty) state_next = bypass ? HOLD : ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (div_ready) state_next = HOLD;
      HOLD:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from the registered state, so they are glitch-free.
  always_comb begin
    fifo_pop  = 1'b0;
    div_start = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE:    fifo_pop  = !fifo_empty;
      ISSUE:   div_start = 1'b1;
      HOLD:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Operand registers: loaded from the FIFO head on a pop that will issue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_dividend <= '0;
      div_divisor  <= '0;
    end else if (fifo_pop && !bypass) begin
      div_dividend <= fifo_head.dividend;
      div_divisor  <= fifo_head.divisor;
    end
  end

  // Result register: captured on the first div_ready in WAIT (or from a
  // bypassed zero divisor); untouched in HOLD so the payload stays frozen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_q <= '0;
    end else if (state == WAIT && div_ready) begin
      rsp_q.quotient  <= div_quotient;
      rsp_q.remainder <= div_remainder;
      rsp_q.div0      <= 1'b0;
    end else if (fifo_pop && bypass) begin
      rsp_q.quotient  <= {WIDTH{1'b1}};
      rsp_q.remainder <= fifo_head.dividend;
      rsp_q.div0      <= 1'b1;
    end
  end

  assign rsp_quotient  = rsp_q.quotient;
  assign rsp_remainder = rsp_q.remainder;
  assign rsp_div0      = rsp_q.div0;

endmodule
